// File: rtl/sm_operand_pairer_pkg.sv
// sm_pkg: shared types and constants for the sign-magnitude operand pairer.
//   sm_word_t    : packed sign-magnitude word (sign bit, 31-bit magnitude)
//   pair_state_e : pairing FSM states
//   SM_MIN_NEG   : the one two's-complement value with no sign-magnitude image
package sm_pkg;
  localparam logic [31:0] SM_MIN_NEG = 32'h8000_0000;
  typedef struct packed {
    logic        sign;
    logic [30:0] mag;
  } sm_word_t;
  typedef enum logic [1:0] {EMPTY, HAVE_A, FULL} pair_state_e;
endpackage

// File: rtl/sm_operand_pairer_if.sv
// sm_operand_pairer_if: operand stream in, operand pair out.
//   in_valid/in_ready/in_data    : two's-complement word stream
//   pair_valid/pair_ready        : pair handshake toward the subtractor
//   num1/num2/sat_flag           : presented pair and its saturation flag
//   pair_count                   : running count of consumed pairs
//   clear                        : synchronous flush
//   slave modport = pairer view, master modport = feeder/consumer view
interface sm_operand_pairer_if #(parameter int WIDTH = 32, parameter int CNT_W = 16);
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             pair_valid;
  logic             pair_ready;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic             sat_flag;
  logic [CNT_W-1:0] pair_count;
  modport slave (
    input  clear, in_valid, in_data, pair_ready,
    output in_ready, pair_valid, num1, num2, sat_flag, pair_count
  );
  modport master (
    output clear, in_valid, in_data, pair_ready,
    input  in_ready, pair_valid, num1, num2, sat_flag, pair_count
  );
endinterface

// File: rtl/sm_operand_pairer_tc_to_sm.sv
// tc_to_sm: combinational two's-complement to sign-magnitude converter.
//   word : 32-bit two's-complement input
//   sm   : sign-magnitude result
//   sat  : word was the most negative value and its magnitude was clamped
module tc_to_sm
  import sm_pkg::*;
(
  input  logic [31:0] word,
  output sm_word_t    sm,
  output logic        sat
);
  logic [31:0] neg;
  assign neg = -word;
  assign sat = word == SM_MIN_NEG;
  // zero has sign 0 already, so -0 cannot appear
  assign sm = {word[31], sat ? 31'h7FFF_FFFF : (word[31] ? neg[30:0] : word[30:0])};
endmodule

// File: rtl/sm_operand_pairer.sv
// sm_operand_pairer: pairs consecutive converted words into (num1, num2) for the subtractor.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of sm_operand_pairer_if (input stream, pair output, clear, count)
module sm_operand_pairer
  import sm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  sm_operand_pairer_if.slave  bus
);
  pair_state_e      state, state_n;
  sm_word_t         cv, a_word, num1_q, num2_q;
  logic             cv_sat, a_sat, sat_q;
  logic             in_fire, pair_fire, load_a, load_pair;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] in_word;
  assign in_word = bus.in_data;
  tc_to_sm u_conv (.word(in_word), .sm(cv), .sat(cv_sat));
  // FULL can still accept when the pair leaves in the same cycle
  assign bus.in_ready   = rst_n & ~bus.clear & ((state != FULL) | bus.pair_ready);
  assign bus.pair_valid = state == FULL;
  assign bus.num1       = num1_q;
  assign bus.num2       = num2_q;
  assign bus.sat_flag   = sat_q;
  assign bus.pair_count = cnt_q;
  assign in_fire   = bus.in_valid & bus.in_ready;
  assign pair_fire = bus.pair_valid & bus.pair_ready & ~bus.clear;
  always_comb begin
    state_n   = state;
    load_a    = 1'b0;
    load_pair = 1'b0;
    case (state)
      EMPTY:   if (in_fire) begin
        load_a  = 1'b1;
        state_n = HAVE_A;
      end
      HAVE_A:  if (in_fire) begin
        load_pair = 1'b1;
        state_n   = FULL;
      end
      FULL:    if (pair_fire) begin
        load_a  = in_fire;
        state_n = in_fire ? HAVE_A : EMPTY;
      end
      default: state_n = EMPTY;
    endcase
    if (bus.clear) begin
      state_n   = EMPTY;
      load_a    = 1'b0;
      load_pair = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_word <= '0;
      a_sat  <= 1'b0;
      num1_q <= '0;
      num2_q <= '0;
      sat_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (load_a) begin
        a_word <= cv;
        a_sat  <= cv_sat;
      end
      if (load_pair) begin
        num1_q <= a_word;
        num2_q <= cv;
        sat_q  <= a_sat | cv_sat;
      end
      if (pair_fire) cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule
